// File: rtl/register_file_scoreboard.sv
// Register file with per-register pending scoreboard and a sweep that clears it.
// Reads are combinational with optional same-cycle write forwarding.
module register_file_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clock,
  input  logic                  Reset_n,
  input  logic [ADDR_WIDTH-1:0] Read_Register1,
  input  logic [ADDR_WIDTH-1:0] Read_Register2,
  output logic [DATA_WIDTH-1:0] Read_Data1,
  output logic [DATA_WIDTH-1:0] Read_Data2,
  output logic                  Read_Valid1,
  output logic                  Read_Valid2,
  input  logic [ADDR_WIDTH-1:0] Write_Register,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  input  logic                  Reg_Write,
  input  logic [ADDR_WIDTH-1:0] Lock_Register,
  input  logic                  Lock_En,
  output logic                  Lock_Error,
  output logic [ADDR_WIDTH:0]   Pending_Count,
  input  logic                  Clear_Req,
  output logic                  Clear_Busy,
  output logic                  Clear_Done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]        pending;
  logic [DEPTH-1:0]        pending_nxt;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [CW-1:0]           cnt_nxt;
  logic                    lock_err_nxt;
  logic                    idle;
  logic                    wr_ok;
  logic                    lock_ok;

  assign idle    = (state == IDLE);
  assign wr_ok   = idle && Reg_Write &&
                   !(ZERO_REG && Write_Register == '0);
  assign lock_ok = idle && Lock_En &&
                   !(ZERO_REG && Lock_Register == '0);

  // Write clears first, lock sets last so a same-cycle lock wins.
  always_comb begin
    pending_nxt  = pending;
    lock_err_nxt = 1'b0;
    if (!idle) pending_nxt[idx] = 1'b0;
    if (wr_ok) pending_nxt[Write_Register] = 1'b0;
    if (lock_ok) begin
      lock_err_nxt = pending[Lock_Register] &&
                     !(wr_ok && Write_Register == Lock_Register);
      pending_nxt[Lock_Register] = 1'b1;
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + CW'(pending_nxt[i]);
  end

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      idx           <= '0;
      pending       <= '0;
      Pending_Count <= '0;
      Lock_Error    <= 1'b0;
      Clear_Busy    <= 1'b0;
      Clear_Done    <= 1'b0;
    end else begin
      pending       <= pending_nxt;
      Pending_Count <= cnt_nxt;
      Lock_Error    <= lock_err_nxt;
      Clear_Done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Clear_Req) begin
            state      <= CLEAR;
            Clear_Busy <= 1'b1;
            idx        <= '0;
          end
        end
        CLEAR: begin
          idx <= idx + 1'b1;
          if (idx == ADDR_WIDTH'(DEPTH - 1)) begin
            state      <= IDLE;
            Clear_Busy <= 1'b0;
            Clear_Done <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (!idle) begin
      regs[idx] <= '0;
    end else if (wr_ok) begin
      regs[Write_Register] <= Write_Data;
    end
  end

  function automatic logic [DATA_WIDTH:0] read_port(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [DATA_WIDTH-1:0] d;
    logic                  v;
    d = regs[a];
    v = !pending[a];
    if (BYPASS && wr_ok && Write_Register == a) begin
      d = Write_Data;
      v = 1'b1;
    end
    if (ZERO_REG && a == '0) begin
      d = '0;
      v = 1'b1;
    end
    // Nothing is trustworthy while the sweep is rewriting the file.
    if (Clear_Busy) v = 1'b0;
    return {v, d};
  endfunction

  assign {Read_Valid1, Read_Data1} = read_port(Read_Register1);
  assign {Read_Valid2, Read_Data2} = read_port(Read_Register2);

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed bench for register_file_scoreboard.
// Each task drives one scenario and checks its own results.
module tb_register_file_scoreboard;

  logic        clock;
  logic        Reset_n;
  logic [5:0]  Read_Register1;
  logic [5:0]  Read_Register2;
  logic [31:0] Read_Data1;
  logic [31:0] Read_Data2;
  logic        Read_Valid1;
  logic        Read_Valid2;
  logic [5:0]  Write_Register;
  logic [31:0] Write_Data;
  logic        Reg_Write;
  logic [5:0]  Lock_Register;
  logic        Lock_En;
  logic        Lock_Error;
  logic [6:0]  Pending_Count;
  logic        Clear_Req;
  logic        Clear_Busy;
  logic        Clear_Done;

  int checks = 0;
  int errors = 0;

  register_file_scoreboard dut (
    .clock          (clock),
    .Reset_n        (Reset_n),
    .Read_Register1 (Read_Register1),
    .Read_Register2 (Read_Register2),
    .Read_Data1     (Read_Data1),
    .Read_Data2     (Read_Data2),
    .Read_Valid1    (Read_Valid1),
    .Read_Valid2    (Read_Valid2),
    .Write_Register (Write_Register),
    .Write_Data     (Write_Data),
    .Reg_Write      (Reg_Write),
    .Lock_Register  (Lock_Register),
    .Lock_En        (Lock_En),
    .Lock_Error     (Lock_Error),
    .Pending_Count  (Pending_Count),
    .Clear_Req      (Clear_Req),
    .Clear_Busy     (Clear_Busy),
    .Clear_Done     (Clear_Done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    Reg_Write = 1'b0;
    Lock_En   = 1'b0;
    Clear_Req = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n        = 1'b0;
    Read_Register1 = 6'd3;
    Read_Register2 = 6'd0;
    Write_Register = 6'd0;
    Write_Data     = 32'h0;
    Lock_Register  = 6'd0;
    idle_inputs();
    #12;
    checks++;
    if (Pending_Count !== 7'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", Pending_Count);
    end
    checks++;
    if ({Lock_Error, Clear_Busy, Clear_Done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000",
               {Lock_Error, Clear_Busy, Clear_Done});
    end
    checks++;
    if (Read_Data1 !== 32'h0 || Read_Valid1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_read: got %h/%b want 0/1",
               Read_Data1, Read_Valid1);
    end
    #2 Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_bypass();
    Reg_Write      = 1'b1;
    Write_Register = 6'd5;
    Write_Data     = 32'hDEADBEEF;
    Read_Register1 = 6'd5;
    Read_Register2 = 6'd5;
    #1;
    checks++;
    if (Read_Data1 !== 32'hDEADBEEF || Read_Valid1 !== 1'b1) begin
      errors++;
      $display("FAIL bypass_port1: got %h/%b want deadbeef/1",
               Read_Data1, Read_Valid1);
    end
    checks++;
    if (Read_Data2 !== 32'hDEADBEEF || Read_Valid2 !== 1'b1) begin
      errors++;
      $display("FAIL bypass_port2: got %h/%b want deadbeef/1",
               Read_Data2, Read_Valid2);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (Read_Data1 !== 32'hDEADBEEF || Read_Valid1 !== 1'b1) begin
      errors++;
      $display("FAIL bypass_stored: got %h/%b want deadbeef/1",
               Read_Data1, Read_Valid1);
    end
  endtask

  task automatic test_zero_reg();
    Reg_Write      = 1'b1;
    Write_Register = 6'd0;
    Write_Data     = 32'h1234;
    Lock_En        = 1'b1;
    Lock_Register  = 6'd0;
    Read_Register1 = 6'd0;
    #1;
    checks++;
    if (Read_Data1 !== 32'h0 || Read_Valid1 !== 1'b1) begin
      errors++;
      $display("FAIL zero_same_cycle: got %h/%b want 0/1",
               Read_Data1, Read_Valid1);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (Read_Data1 !== 32'h0 || Read_Valid1 !== 1'b1) begin
      errors++;
      $display("FAIL zero_after: got %h/%b want 0/1",
               Read_Data1, Read_Valid1);
    end
    checks++;
    if (Pending_Count !== 7'd0 || Lock_Error !== 1'b0) begin
      errors++;
      $display("FAIL zero_pending: got %0d/%b want 0/0",
               Pending_Count, Lock_Error);
    end
  endtask

  task automatic test_lock_error();
    Read_Register1 = 6'd7;
    Lock_En        = 1'b1;
    Lock_Register  = 6'd7;
    tick();
    checks++;
    if (Read_Valid1 !== 1'b0 || Pending_Count !== 7'd1 ||
        Lock_Error !== 1'b0) begin
      errors++;
      $display("FAIL lock_first: got v=%b n=%0d e=%b want 0/1/0",
               Read_Valid1, Pending_Count, Lock_Error);
    end
    tick();
    Lock_En = 1'b0;
    checks++;
    if (Lock_Error !== 1'b1 || Pending_Count !== 7'd1 ||
        Read_Valid1 !== 1'b0) begin
      errors++;
      $display("FAIL lock_again: got e=%b n=%0d v=%b want 1/1/0",
               Lock_Error, Pending_Count, Read_Valid1);
    end
    tick();
    checks++;
    if (Lock_Error !== 1'b0) begin
      errors++;
      $display("FAIL lock_err_pulse: got %b want 0", Lock_Error);
    end
    Reg_Write      = 1'b1;
    Write_Register = 6'd7;
    Write_Data     = 32'h55;
    #1;
    checks++;
    if (Read_Valid1 !== 1'b1 || Read_Data1 !== 32'h55) begin
      errors++;
      $display("FAIL lock_write_fwd: got %h/%b want 55/1",
               Read_Data1, Read_Valid1);
    end
    tick();
    Reg_Write = 1'b0;
    #1;
    checks++;
    if (Read_Valid1 !== 1'b1 || Pending_Count !== 7'd0 ||
        Read_Data1 !== 32'h55) begin
      errors++;
      $display("FAIL lock_released: got %h/%b n=%0d want 55/1/0",
               Read_Data1, Read_Valid1, Pending_Count);
    end
  endtask

  task automatic test_write_lock_same();
    Read_Register1 = 6'd9;
    Reg_Write      = 1'b1;
    Write_Register = 6'd9;
    Write_Data     = 32'hA5A50009;
    Lock_En        = 1'b1;
    Lock_Register  = 6'd9;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (Read_Data1 !== 32'hA5A50009 || Read_Valid1 !== 1'b0) begin
      errors++;
      $display("FAIL wl_data: got %h/%b want a5a50009/0",
               Read_Data1, Read_Valid1);
    end
    checks++;
    if (Pending_Count !== 7'd1 || Lock_Error !== 1'b0) begin
      errors++;
      $display("FAIL wl_count: got %0d/%b want 1/0",
               Pending_Count, Lock_Error);
    end
    Reg_Write  = 1'b1;
    Write_Data = 32'h77;
    Lock_En    = 1'b1;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (Lock_Error !== 1'b0 || Pending_Count !== 7'd1 ||
        Read_Data1 !== 32'h77 || Read_Valid1 !== 1'b0) begin
      errors++;
      $display("FAIL wl_repeat: got e=%b n=%0d %h/%b want 0/1/77/0",
               Lock_Error, Pending_Count, Read_Data1, Read_Valid1);
    end
  endtask

  task automatic test_clear();
    int busy_n;
    int bad_valid;
    int bad_err;
    int early_done;
    busy_n     = 0;
    bad_valid  = 0;
    bad_err    = 0;
    early_done = 0;
    Lock_En       = 1'b1;
    Lock_Register = 6'd3;
    tick();
    Lock_Register = 6'd4;
    tick();
    Lock_En = 1'b0;
    checks++;
    if (Pending_Count !== 7'd3) begin
      errors++;
      $display("FAIL clr_pre_count: got %0d want 3", Pending_Count);
    end
    Clear_Req = 1'b1;
    tick();
    Reg_Write      = 1'b1;
    Write_Register = 6'd10;
    Write_Data     = 32'hFFFF;
    Lock_En        = 1'b1;
    Lock_Register  = 6'd9;
    Read_Register1 = 6'd10;
    while (Clear_Busy === 1'b1 && busy_n < 200) begin
      busy_n++;
      if (Read_Valid1 !== 1'b0) bad_valid++;
      if (Lock_Error !== 1'b0) bad_err++;
      if (Clear_Done !== 1'b0) early_done++;
      tick();
    end
    idle_inputs();
    checks++;
    if (busy_n != 64) begin
      errors++;
      $display("FAIL clr_busy_len: got %0d want 64", busy_n);
    end
    checks++;
    if (bad_valid != 0 || bad_err != 0 || early_done != 0) begin
      errors++;
      $display("FAIL clr_during: got v=%0d e=%0d d=%0d want 0/0/0",
               bad_valid, bad_err, early_done);
    end
    checks++;
    if (Clear_Done !== 1'b1) begin
      errors++;
      $display("FAIL clr_done: got %b want 1", Clear_Done);
    end
    Read_Register1 = 6'd5;
    Read_Register2 = 6'd9;
    tick();
    checks++;
    if (Clear_Done !== 1'b0 || Pending_Count !== 7'd0) begin
      errors++;
      $display("FAIL clr_after: got d=%b n=%0d want 0/0",
               Clear_Done, Pending_Count);
    end
    checks++;
    if (Read_Data1 !== 32'h0 || Read_Data2 !== 32'h0 ||
        Read_Valid1 !== 1'b1 || Read_Valid2 !== 1'b1) begin
      errors++;
      $display("FAIL clr_reads_a: got %h/%b %h/%b want 0/1 0/1",
               Read_Data1, Read_Valid1, Read_Data2, Read_Valid2);
    end
    Read_Register1 = 6'd10;
    Read_Register2 = 6'd7;
    #1;
    checks++;
    if (Read_Data1 !== 32'h0 || Read_Data2 !== 32'h0 ||
        Read_Valid1 !== 1'b1 || Read_Valid2 !== 1'b1) begin
      errors++;
      $display("FAIL clr_reads_b: got %h/%b %h/%b want 0/1 0/1",
               Read_Data1, Read_Valid1, Read_Data2, Read_Valid2);
    end
  endtask

  task automatic test_reset_mid_sweep();
    Reg_Write      = 1'b1;
    Write_Register = 6'd40;
    Write_Data     = 32'h40;
    tick();
    Reg_Write     = 1'b0;
    Lock_En       = 1'b1;
    Lock_Register = 6'd13;
    tick();
    Lock_En   = 1'b0;
    Clear_Req = 1'b1;
    tick();
    Clear_Req = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (Clear_Busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_sweep_running: got %b want 1", Clear_Busy);
    end
    Read_Register1 = 6'd40;
    Reset_n        = 1'b0;
    #1;
    checks++;
    if ({Clear_Busy, Clear_Done, Lock_Error} !== 3'b000 ||
        Pending_Count !== 7'd0) begin
      errors++;
      $display("FAIL rst_mid_flags: got %b n=%0d want 000/0",
               {Clear_Busy, Clear_Done, Lock_Error}, Pending_Count);
    end
    checks++;
    if (Read_Data1 !== 32'h0 || Read_Valid1 !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_read: got %h/%b want 0/1",
               Read_Data1, Read_Valid1);
    end
    #2 Reset_n = 1'b1;
    Reg_Write      = 1'b1;
    Write_Register = 6'd21;
    Write_Data     = 32'hCAFE;
    Read_Register1 = 6'd21;
    tick();
    Reg_Write = 1'b0;
    #1;
    checks++;
    if (Read_Data1 !== 32'hCAFE || Read_Valid1 !== 1'b1 ||
        Clear_Busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_write_after: got %h/%b b=%b want cafe/1/0",
               Read_Data1, Read_Valid1, Clear_Busy);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_lock_error();
    test_write_lock_same();
    test_clear();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_scoreboard.md
REGISTER_FILE_SCOREBOARD -- requirements
Module: register_file_scoreboard

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, register address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding is enabled.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with the ports defined in REQ-006 and REQ-007.
REQ-006 SHALL have port clock  in  1  sole clock; all state changes on its rising edge.
REQ-007 SHALL have port Reset_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports Read_Register1, Read_Register2  in  ADDR_WIDTH  read addresses.
REQ-009 SHALL have ports Read_Data1, Read_Data2  out  DATA_WIDTH  combinational read data.
REQ-010 SHALL have ports Read_Valid1, Read_Valid2  out  1  high when the read data is not pending.
REQ-011 SHALL have port Write_Register  in  ADDR_WIDTH  write address.
REQ-012 SHALL have port Write_Data  in  DATA_WIDTH  write data.
REQ-013 SHALL have port Reg_Write  in  1  write enable.
REQ-014 SHALL have port Lock_Register  in  ADDR_WIDTH  destination register of an issued multi-cycle operation.
REQ-015 SHALL have port Lock_En  in  1  marks Lock_Register as pending.
REQ-016 SHALL have port Lock_Error  out  1  one-cycle pulse when a lock targets an already-pending register.
REQ-017 SHALL have port Pending_Count  out  ADDR_WIDTH+1  number of pending registers.
REQ-018 SHALL have port Clear_Req  in  1  requests a sweep that zeroes every register.
REQ-019 SHALL have port Clear_Busy  out  1  high while the sweep runs.
REQ-020 SHALL have port Clear_Done  out  1  one-cycle pulse when the sweep completes.

Function
REQ-021 SHALL provide combinational reads: Read_DataN = reg[Read_RegisterN].
REQ-022 SHALL forward Write_Data to Read_DataN when BYPASS=1, Reg_Write=1, Write_Register==Read_RegisterN, and the FSM is IDLE.
REQ-023 SHALL, when ZERO_REG=1, always return 0 for reads of address 0 with ReadValidN=1, and ignore writes and locks to address 0.
REQ-024 SHALL drive Read_ValidN = !pending[Read_RegisterN], or 1 when REQ-022 forwarding applies; Read_ValidN is forced to 0 while Clear_Busy=1.
REQ-025 SHALL, when Reg_Write=1, write reg[Write_Register] <= Write_Data and clear pending[Write_Register] at the next rising edge.
REQ-026 SHALL, when Lock_En=1 and pending[Lock_Register]=0, set pending[Lock_Register] at the next rising edge.
REQ-027 SHALL, when Lock_En=1 and pending[Lock_Register]=1, register Lock_Error=1 for exactly one cycle and leave pending set.
REQ-028 SHALL, when Reg_Write and Lock_En target the same register in the same cycle, store the data and leave pending=1 (lock wins), with no Lock_Error.
REQ-029 SHALL register Pending_Count so that it always equals the popcount of the pending bits after each edge; its range is 0..DEPTH.
REQ-030 SHALL implement the sweep with FSM states IDLE and CLEAR, which transition as follows:
- IDLE -> CLEAR on Clear_Req=1, with the index set to 0.
- In CLEAR, each edge sets reg[index]=0 and pending[index]=0, then increments index.
- CLEAR -> IDLE on the edge that clears index DEPTH-1; the sweep takes exactly DEPTH cycles.
REQ-031 SHALL hold Clear_Busy=1 in CLEAR and assert Clear_Done for exactly the one cycle following the final edge of the sweep.
REQ-032 SHALL, in CLEAR, ignore Reg_Write, Lock_En and Clear_Req, without raising Lock_Error.
REQ-033 SHALL wrap the index without overflow; the index width is ADDR_WIDTH.

Reset
REQ-034 SHALL, on Reset_n=0 at any time including mid-sweep, immediately zero all registers, pending bits, Pending_Count, Lock_Error, Clear_Busy, Clear_Done and the index, and set the FSM to IDLE.
REQ-035 SHALL resume normal operation on the first rising edge after Reset_n returns to 1.

Verification
REQ-036 SHALL cover this scenario: write reg5=0xDEADBEEF and read reg5 in the same cycle -> Read_Data1=0xDEADBEEF and Read_Valid1=1 (bypass); next cycle the stored value is 0xDEADBEEF.
REQ-037 SHALL cover this scenario: write reg0=0x1234 and lock reg0 -> Read_Data of reg0 is 0, Read_Valid is 1, and Pending_Count is 0.
REQ-038 SHALL cover this scenario: lock reg7, then lock reg7 again -> Read_Valid=0 for reg7, Lock_Error pulses once, and Pending_Count=1; write reg7=0x55 -> Read_Valid=1 and Pending_Count=0.
REQ-039 SHALL cover this scenario: write and lock reg9 in the same cycle -> reg9 holds the written data, Read_Valid=0, and Pending_Count=1.
REQ-040 SHALL cover this scenario: lock 3 registers, then pulse Clear_Req -> Clear_Busy is high for 64 cycles (defaults), writes during the sweep are dropped, Clear_Done pulses once, and afterwards all reads return 0 and Pending_Count=0.
REQ-041 SHALL cover this scenario: assert Reset_n=0 at sweep index 20 -> all outputs are 0 immediately, the FSM is IDLE, and a write after release succeeds.
